// File: rtl/microwave_ctrl.sv
// Microwave oven control FSM: IDLE/RUN/PAUSE/DONE with tick prescaler and beep timer.
// Define MICROWAVE_DOOR_INTERLOCK_EN to honour door_closed; otherwise the door is treated as always shut.
module microwave_ctrl #(
    parameter int unsigned TICK_DIV    = 50000000,
    parameter int unsigned BEEP_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       set,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic       timer_load,
    output logic       timer_enable,
    output logic       timer_clearn,
    output logic       mag_on,
    output logic       beep,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BEEP_LAST  = BW'(BEEP_CYCLES - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] beep_q, beep_d;
    logic          load_q, load_d;
    logic          tick_q, tick_d;
    logic          clearn_q, clearn_d;
    logic          door;

`ifdef MICROWAVE_DOOR_INTERLOCK_EN
    assign door = door_closed;
`else
    logic door_closed_unused;
    assign door_closed_unused = door_closed;
    assign door = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        beep_d   = '0;
        load_d   = 1'b0;
        tick_d   = 1'b0;
        clearn_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (set) begin
                    load_d = 1'b1;
                end else if (start && door && !timer_zero) begin
                    state_d = RUN;
                    presc_d = '0;
                end
            end
            RUN: begin
                // Prescaler only advances while staying in RUN so a pause holds the partial tick.
                if (timer_zero) begin
                    state_d = DONE;
                end else if (stop || !door) begin
                    state_d = PAUSE;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            PAUSE: begin
                if (stop) begin
                    clearn_d = 1'b0;
                    state_d  = IDLE;
                end else if (start && door) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (stop || beep_q == BEEP_LAST) begin
                    state_d = IDLE;
                end else begin
                    beep_d = beep_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            beep_q   <= '0;
            load_q   <= 1'b0;
            tick_q   <= 1'b0;
            clearn_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            beep_q   <= beep_d;
            load_q   <= load_d;
            tick_q   <= tick_d;
            clearn_q <= clearn_d;
        end
    end

    assign state        = state_q;
    assign mag_on       = (state_q == RUN);
    assign beep         = (state_q == DONE);
    assign timer_enable = tick_q && (state_q == RUN);
    assign timer_load   = load_q;
    assign timer_clearn = clearn_q;

endmodule
